// File: rtl/pcs_10g_enc.sv
// pcs_10g_enc: 10GBASE-R 64b/66b transmit encoder with the cl.49 TX state machine.
// Define PCS_ENC_SCRAMBLE_EN to scramble the payload with x^58+x^39+1 before output.
module pcs_10g_enc #(
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int BLOCK_W = 64,
  parameter int CNT_N   = BLOCK_W / DATA_W,
  parameter int CNT_W   = (CNT_N > 1) ? $clog2(CNT_N) : 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en_i,
  input  logic [DATA_W-1:0] txd_i,
  input  logic [KEEP_W-1:0] txc_i,
  output logic [CNT_W-1:0]  part_o,
  output logic              head_v_o,
  output logic [1:0]        sync_head_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  localparam logic [7:0] CH_I = 8'h07;
  localparam logic [7:0] CH_S = 8'hFB;
  localparam logic [7:0] CH_T = 8'hFD;
  localparam logic [7:0] CH_E = 8'hFE;
  localparam logic [7:0] CH_O = 8'h9C;

  localparam logic [2:0] CL_C = 3'd0;
  localparam logic [2:0] CL_S = 3'd1;
  localparam logic [2:0] CL_T = 3'd2;
  localparam logic [2:0] CL_D = 3'd3;
  localparam logic [2:0] CL_E = 3'd4;

  localparam logic [2:0] TX_INIT = 3'd0;
  localparam logic [2:0] TX_C    = 3'd1;
  localparam logic [2:0] TX_D    = 3'd2;
  localparam logic [2:0] TX_T    = 3'd3;
  localparam logic [2:0] TX_E    = 3'd4;

  localparam logic [BLOCK_W-1:0] EBLOCK_PAY = {{8{7'h1E}}, 8'h1E};

  typedef struct packed {
    logic [2:0]         cls;
    logic [1:0]         hdr;
    logic [BLOCK_W-1:0] pay;
  } enc_t;

  function automatic logic [6:0] ccode(input logic [7:0] ch);
    return (ch == CH_I) ? 7'h00 : 7'h1E;
  endfunction

  function automatic logic [7:0] ttype(input int k);
    logic [7:0] t;
    case (k)
      0:       t = 8'h87;
      1:       t = 8'h99;
      2:       t = 8'hAA;
      3:       t = 8'hB4;
      4:       t = 8'hCC;
      5:       t = 8'hD2;
      6:       t = 8'hE1;
      default: t = 8'hFF;
    endcase
    return t;
  endfunction

  function automatic enc_t classify(input logic [BLOCK_W-1:0] d, input logic [7:0] c);
    enc_t r;
    logic all_ie;
    r.cls  = CL_E;
    r.hdr  = 2'b10;
    r.pay  = EBLOCK_PAY;
    all_ie = (c == 8'hFF);
    for (int i = 0; i < 8; i++)
      if (d[8*i +: 8] != CH_I && d[8*i +: 8] != CH_E) all_ie = 1'b0;
    if (c == 8'h00) begin
      r.cls = CL_D;
      r.hdr = 2'b01;
      r.pay = d;
    end else if (all_ie) begin
      r.cls      = CL_C;
      r.pay      = '0;
      r.pay[7:0] = 8'h1E;
      for (int i = 0; i < 8; i++) r.pay[8+7*i +: 7] = ccode(d[8*i +: 8]);
    end else if (c == 8'hF1 && d[7:0] == CH_O) begin
      // O-code 0x0 sits in bits [35:32], already cleared
      r.cls       = CL_C;
      r.pay       = '0;
      r.pay[7:0]  = 8'h4B;
      r.pay[31:8] = d[31:8];
      for (int i = 4; i < 8; i++) r.pay[36+7*(i-4) +: 7] = ccode(d[8*i +: 8]);
    end else if (c == 8'h01 && d[7:0] == CH_S) begin
      r.cls = CL_S;
      r.pay = {d[63:8], 8'h78};
    end else if (c == 8'h1F && d[39:32] == CH_S) begin
      r.cls        = CL_S;
      r.pay        = '0;
      r.pay[7:0]   = 8'h33;
      for (int i = 0; i < 4; i++) r.pay[8+7*i +: 7] = ccode(d[8*i +: 8]);
      r.pay[63:40] = d[63:40];
    end else begin
      // Trailing controls after /T/ are sent as idle, i.e. all-zero bits
      for (int k = 0; k < 8; k++)
        if (c == 8'(8'hFF << k) && d[8*k +: 8] == CH_T) begin
          r.cls = CL_T;
          r.pay = ((d & ((64'd1 << (8*k)) - 64'd1)) << 8) | {56'd0, ttype(k)};
        end
    end
    return r;
  endfunction

  function automatic logic [2:0] fsm_next(input logic [2:0] st, input logic [2:0] cls);
    logic [2:0] n;
    n = TX_E;
    case (st)
      TX_INIT, TX_C, TX_T: begin
        if (cls == CL_C) n = TX_C;
        else if (cls == CL_S) n = TX_D;
      end
      TX_D: begin
        if (cls == CL_D) n = TX_D;
        else if (cls == CL_T) n = TX_T;
      end
      default: begin
        if (cls == CL_C) n = TX_C;
        else if (cls == CL_D) n = TX_D;
        else if (cls == CL_T) n = TX_T;
      end
    endcase
    return n;
  endfunction

`ifdef PCS_ENC_SCRAMBLE_EN
  function automatic logic [BLOCK_W+57:0] scramble(input logic [BLOCK_W-1:0] d,
                                                    input logic [57:0] s);
    logic [57:0]        st;
    logic [BLOCK_W-1:0] o;
    logic               b;
    st = s;
    for (int i = 0; i < BLOCK_W; i++) begin
      b    = d[i] ^ st[38] ^ st[57];
      o[i] = b;
      st   = {st[56:0], b};
    end
    return {st, o};
  endfunction
`endif

  logic [CNT_W-1:0]                part_q, part_d;
  logic [2:0]                      state_q, state_d;
  logic                            valid_q, valid_d;
  logic [1:0]                      sync_q, sync_d;
  logic [CNT_N-1:0][DATA_W-1:0]    oblk_q, oblk_d;
  logic [BLOCK_W-1:0]              blk_d;
  logic [7:0]                      blk_c;
  logic                            last_beat;
  logic [2:0]                      state_nx;
  enc_t                            enc;
  logic [1:0]                      hdr_sel;
  logic [BLOCK_W-1:0]              pay_sel;
  logic [BLOCK_W-1:0]              pay_out;

  assign last_beat = (part_q == CNT_W'(CNT_N - 1));

  // Assembly: earlier beats wait in the buffer, the final beat joins combinationally
  if (CNT_N == 1) begin : g_single
    assign blk_d = txd_i;
    assign blk_c = txc_i;
  end else begin : g_multi
    logic [(CNT_N-1)*DATA_W-1:0] dbuf_q, dbuf_d;
    logic [(CNT_N-1)*KEEP_W-1:0] cbuf_q, cbuf_d;

    always_comb begin
      dbuf_d = dbuf_q;
      cbuf_d = cbuf_q;
      for (int p = 0; p < CNT_N - 1; p++)
        if (en_i && part_q == CNT_W'(p)) begin
          dbuf_d[p*DATA_W +: DATA_W] = txd_i;
          cbuf_d[p*KEEP_W +: KEEP_W] = txc_i;
        end
    end

    always_ff @(posedge clk) begin
      dbuf_q <= dbuf_d;
      cbuf_q <= cbuf_d;
    end

    assign blk_d = {txd_i, dbuf_q};
    assign blk_c = {txc_i, cbuf_q};
  end

  assign enc      = classify(blk_d, blk_c);
  assign state_nx = fsm_next(state_q, enc.cls);
  assign hdr_sel  = (state_nx == TX_E) ? 2'b10 : enc.hdr;
  assign pay_sel  = (state_nx == TX_E) ? EBLOCK_PAY : enc.pay;

`ifdef PCS_ENC_SCRAMBLE_EN
  logic [57:0]          scr_q, scr_d;
  logic [BLOCK_W+57:0]  scr_res;

  assign scr_res = scramble(pay_sel, scr_q);
  assign pay_out = scr_res[BLOCK_W-1:0];

  always_comb begin
    scr_d = scr_q;
    if (en_i && last_beat) scr_d = scr_res[BLOCK_W+57:BLOCK_W];
  end

  always_ff @(posedge clk) begin
    if (!nreset) scr_q <= '1;
    else         scr_q <= scr_d;
  end
`else
  assign pay_out = pay_sel;
`endif

  // Output register: loaded on the final beat, parts shown in lockstep with input parts
  always_comb begin
    part_d  = part_q;
    state_d = state_q;
    valid_d = valid_q;
    sync_d  = sync_q;
    oblk_d  = oblk_q;
    if (en_i) begin
      part_d = last_beat ? '0 : part_q + CNT_W'(1);
      if (last_beat) begin
        state_d = state_nx;
        valid_d = 1'b1;
        sync_d  = hdr_sel;
        oblk_d  = pay_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      part_q  <= '0;
      state_q <= TX_INIT;
      valid_q <= 1'b0;
      sync_q  <= 2'b00;
      oblk_q  <= '0;
    end else begin
      part_q  <= part_d;
      state_q <= state_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      oblk_q  <= oblk_d;
    end
  end

  if (CNT_N == 1) begin : g_out_single
    assign data_o = oblk_q[0];
  end else begin : g_out_multi
    assign data_o = oblk_q[part_q];
  end

  assign part_o      = part_q;
  assign valid_o     = valid_q;
  assign sync_head_o = sync_q;
  assign head_v_o    = valid_q & (part_q == '0);

endmodule
